// File: rtl/button_press_emulator.sv
// button_press_emulator: pulse-to-button waveform (LOW hold, HIGH gap); define BOUNCE_EN to prepend a 0,1,0.. bounce burst.
module button_press_emulator #(
  parameter int HOLD_CYCLES   = 8,
  parameter int GAP_CYCLES    = 4,
  parameter int CNT_W         = 8,
  parameter int BOUNCE_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic controlFlag,
  input  logic pulse_IN,
  output logic button_OUT,
  output logic busy,
  output logic done
);
  if (HOLD_CYCLES < 1 || GAP_CYCLES < 1 || BOUNCE_CYCLES < 1 ||
      HOLD_CYCLES >= (1 << CNT_W) || GAP_CYCLES >= (1 << CNT_W)) begin : g_bad_param
    $error("button_press_emulator: invalid parameters");
  end
  typedef enum logic [1:0] {IDLE, PRESS, GAP
`ifdef BOUNCE_EN
    , BOUNCE
`endif
  } state_t;
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);
`ifdef BOUNCE_EN
  localparam logic [CNT_W-1:0] BNC_LD = CNT_W'(BOUNCE_CYCLES - 1);
  localparam state_t FIRST = BOUNCE;
  localparam logic [CNT_W-1:0] FIRST_LD = BNC_LD;
  logic [CNT_W-1:0] bk;
`else
  localparam state_t FIRST = PRESS;
  localparam logic [CNT_W-1:0] FIRST_LD = HOLD_LD;
`endif
  state_t state, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic pending, pending_nxt, req, btn_nxt, last;
  always_comb begin
    req = controlFlag & pulse_IN;
    last = cnt == '0;
    nxt = state;
    cnt_nxt = cnt;
    pending_nxt = pending;
    btn_nxt = 1'b1;
    case (state)
      IDLE: begin
        nxt = req ? FIRST : IDLE;
        cnt_nxt = req ? FIRST_LD : cnt;
      end
      PRESS: begin
        nxt = last ? GAP : PRESS;
        cnt_nxt = last ? GAP_LD : cnt - 1'b1;
        pending_nxt = pending | req;
      end
      GAP: begin
        nxt = !last ? GAP : (pending | req) ? FIRST : IDLE;
        cnt_nxt = !last ? cnt - 1'b1 : (pending | req) ? FIRST_LD : cnt;
        pending_nxt = last ? 1'b0 : pending | req;
      end
`ifdef BOUNCE_EN
      BOUNCE: begin
        nxt = last ? PRESS : BOUNCE;
        cnt_nxt = last ? HOLD_LD : cnt - 1'b1;
        pending_nxt = pending | req;
      end
`endif
      default: nxt = IDLE;
    endcase
`ifdef BOUNCE_EN
    // bounce cycle index k counts up while the counter counts down
    bk = BNC_LD - cnt_nxt;
    btn_nxt = (nxt == BOUNCE) ? bk[0] : nxt != PRESS;
`else
    btn_nxt = nxt != PRESS;
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      pending <= 1'b0;
      button_OUT <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      pending <= pending_nxt;
      button_OUT <= btn_nxt;
      busy <= nxt != IDLE;
      done <= state == GAP && last;
    end
  end
endmodule

// File: tb/tb_button_press_emulator.sv
// tb_button_press_emulator: directed vectors over 32-cycle windows, one bit per cycle.
module tb_button_press_emulator;
  logic clk = 1'b0, rst = 1'b0, controlFlag = 1'b0, pulse_IN = 1'b0;
  logic button_OUT, busy, done;
  int n_cmp = 0, n_bad = 0;
`ifdef BOUNCE_EN
  localparam int B = 3;
`else
  localparam int B = 0;
`endif
  localparam int L = 12 + B;
  logic [31:0] bv, yv, dv, ex;
  always #5 clk = ~clk;
  button_press_emulator dut (
    .clk(clk), .rst(rst), .controlFlag(controlFlag), .pulse_IN(pulse_IN),
    .button_OUT(button_OUT), .busy(busy), .done(done)
  );
  function automatic logic [31:0] rng(input int lo, input int hi);
    logic [31:0] r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction
  function automatic logic [31:0] bnc(input int s);
    return (B > 0) ? (32'd1 << (s + 1)) : 32'd0;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [31:0] p, input logic [31:0] cf, input logic [31:0] rl);
    for (int i = 0; i < 32; i++) begin
      pulse_IN = p[i];
      controlFlag = cf[i];
      rst = ~rl[i];
      bv[i] = button_OUT;
      yv[i] = busy;
      dv[i] = done;
      @(posedge clk);
      #1;
    end
    pulse_IN = 1'b0;
    rst = 1'b1;
  endtask
  initial begin
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("rst_btn", {31'd0, button_OUT}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b1;
    controlFlag = 1'b1;
    @(posedge clk);
    #1;
    run(32'h1, '1, '0);
    check("single_btn", bv, ~rng(1, 8 + B) | bnc(1));
    check("single_busy", yv, rng(1, L));
    check("single_done", dv, 32'd1 << (L + 1));
    run(32'h155, '0, '0);
    check("gated_btn", bv, '1);
    check("gated_busy", yv, '0);
    check("gated_done", dv, '0);
    ex = ~rng(1, 8 + B) & ~rng(L + 1, L + 8 + B) | bnc(1) | bnc(L + 1);
    run(32'h29, '1, '0);
    check("chain_btn", bv, ex);
    check("chain_busy", yv, rng(1, 2 * L));
    check("chain_done", dv, (32'd1 << (L + 1)) | (32'd1 << (2 * L + 1)));
    run(32'h1 | (32'd1 << L), '1, '0);
    check("lastgap_btn", bv, ex);
    check("lastgap_busy", yv, rng(1, 2 * L));
    check("lastgap_done", dv, (32'd1 << (L + 1)) | (32'd1 << (2 * L + 1)));
    run(32'h9 | (32'd1 << 20), 32'hF, '0);
    check("cfdrop_btn", bv, ex);
    check("cfdrop_busy", yv, rng(1, 2 * L));
    check("cfdrop_done", dv, (32'd1 << (L + 1)) | (32'd1 << (2 * L + 1)));
    run(32'h5, '1, 32'h10);
    check("rstmid_btn", bv, ~rng(1, 4) | bnc(1));
    check("rstmid_busy", yv, rng(1, 4));
    check("rstmid_done", dv, '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
